// File: rtl/cmd_dispatch.sv
// Three-byte UART command dispatcher: drives SPI targets, capture config registers and dump requests.
// Optional build macro CMD_TIMEOUT_EN abandons a partially received command after 0xFFFF idle cycles.
`timescale 1ns/1ps
module cmd_dispatch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_rd,
    output logic [2:0]  ss_sel,
    output logic [8:0]  trig_pos,
    output logic [3:0]  decimator,
    output logic [5:0]  trig_cfg,
    output logic        dump_req,
    output logic [1:0]  dump_ch,
    input  logic        dump_done,
    input  logic        capture_done
);
    localparam logic [7:0] OP_DUMP_CH  = 8'h01;
    localparam logic [7:0] OP_CFG_GAIN = 8'h02;
    localparam logic [7:0] OP_TRIG_LVL = 8'h03;
    localparam logic [7:0] OP_TRIG_POS = 8'h04;
    localparam logic [7:0] OP_SET_DEC  = 8'h05;
    localparam logic [7:0] OP_TRIG_CFG = 8'h06;
    localparam logic [7:0] OP_TRIG_RD  = 8'h07;
    localparam logic [7:0] OP_EEP_WRT  = 8'h08;
    localparam logic [7:0] OP_EEP_RD   = 8'h09;
    localparam logic [7:0] RESP_ACK    = 8'hA5;
    localparam logic [7:0] RESP_NAK    = 8'hEE;

    typedef enum logic [3:0] {IDLE, RX2, RX3, DECODE, SPI1, SPI2, DUMP, RESP, RESP_WAIT} state_t;

    state_t     state_reg;
    logic [7:0] opcode_reg;
    logic [5:0] byte2_reg;
    logic [7:0] byte3_reg;
    logic [7:0] resp_reg;
    logic       rx_accept;
    logic       timeout_hit;
    logic       unused_spi_hi;

    // The UART flag is still high during the acknowledge cycle, so ignore it then.
    assign rx_accept     = rx_rdy && !clr_rx_rdy;
    assign unused_spi_hi = &{1'b0, spi_rd[15:8]};

    function automatic logic [7:0] gain_code(input logic [2:0] sel);
        case (sel)
            3'd0:    gain_code = 8'h02;
            3'd1:    gain_code = 8'h05;
            3'd2:    gain_code = 8'h09;
            3'd3:    gain_code = 8'h13;
            3'd4:    gain_code = 8'h27;
            3'd5:    gain_code = 8'h4B;
            3'd6:    gain_code = 8'h8E;
            default: gain_code = 8'hD1;
        endcase
    endfunction

`ifdef CMD_TIMEOUT_EN
    logic [15:0] idle_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_reg <= '0;
        end else if ((state_reg == RX2 || state_reg == RX3) && !rx_accept) begin
            if (idle_cnt_reg != 16'hFFFF)
                idle_cnt_reg <= idle_cnt_reg + 16'd1;
        end else begin
            idle_cnt_reg <= '0;
        end
    end

    assign timeout_hit = (idle_cnt_reg == 16'hFFFF);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            opcode_reg <= '0;
            byte2_reg  <= '0;
            byte3_reg  <= '0;
            resp_reg   <= '0;
            clr_rx_rdy <= 1'b0;
            trmt       <= 1'b0;
            tx_data    <= '0;
            spi_wrt    <= 1'b0;
            spi_cmd    <= '0;
            ss_sel     <= '0;
            trig_pos   <= 9'h100;
            decimator  <= '0;
            trig_cfg   <= 6'h03;
            dump_req   <= 1'b0;
            dump_ch    <= '0;
        end else begin
            clr_rx_rdy <= 1'b0;
            trmt       <= 1'b0;
            spi_wrt    <= 1'b0;
            // A TRIG_CFG write later in this block overrides the capture flag.
            if (capture_done)
                trig_cfg[5] <= 1'b1;

            case (state_reg)
                IDLE: if (rx_accept) begin
                    opcode_reg <= rx_data;
                    clr_rx_rdy <= 1'b1;
                    state_reg  <= RX2;
                end
                RX2: if (rx_accept) begin
                    byte2_reg  <= rx_data[5:0];
                    clr_rx_rdy <= 1'b1;
                    state_reg  <= RX3;
                end else if (timeout_hit) begin
                    state_reg  <= IDLE;
                end
                RX3: if (rx_accept) begin
                    byte3_reg  <= rx_data;
                    clr_rx_rdy <= 1'b1;
                    state_reg  <= DECODE;
                end else if (timeout_hit) begin
                    state_reg  <= IDLE;
                end
                DECODE: begin
                    resp_reg  <= RESP_ACK;
                    state_reg <= RESP;
                    case (opcode_reg)
                        OP_DUMP_CH: begin
                            dump_req  <= 1'b1;
                            dump_ch   <= byte2_reg[1:0];
                            state_reg <= DUMP;
                        end
                        OP_CFG_GAIN: if (byte2_reg[1:0] == 2'd3) begin
                            resp_reg  <= RESP_NAK;
                        end else begin
                            spi_cmd   <= {8'h13, gain_code(byte2_reg[4:2])};
                            ss_sel    <= {1'b0, byte2_reg[1:0]};
                            spi_wrt   <= 1'b1;
                            state_reg <= SPI1;
                        end
                        OP_TRIG_LVL: if (byte3_reg >= 8'd46 && byte3_reg <= 8'd201) begin
                            spi_cmd   <= {8'h13, byte3_reg};
                            ss_sel    <= 3'd3;
                            spi_wrt   <= 1'b1;
                            state_reg <= SPI1;
                        end else begin
                            resp_reg  <= RESP_NAK;
                        end
                        OP_TRIG_POS: trig_pos  <= {byte2_reg[0], byte3_reg};
                        OP_SET_DEC:  decimator <= byte3_reg[3:0];
                        OP_TRIG_CFG: trig_cfg  <= byte2_reg;
                        OP_TRIG_RD:  resp_reg  <= {2'b00, trig_cfg};
                        OP_EEP_WRT: begin
                            spi_cmd   <= {2'b01, byte2_reg, byte3_reg};
                            ss_sel    <= 3'd4;
                            spi_wrt   <= 1'b1;
                            state_reg <= SPI1;
                        end
                        OP_EEP_RD: begin
                            spi_cmd   <= {2'b00, byte2_reg, 8'h00};
                            ss_sel    <= 3'd4;
                            spi_wrt   <= 1'b1;
                            state_reg <= SPI1;
                        end
                        default: resp_reg <= RESP_NAK;
                    endcase
                end
                SPI1: if (spi_done) begin
                    if (opcode_reg == OP_EEP_RD) begin
                        // Second word clocks out the addressed EEPROM byte.
                        spi_cmd   <= 16'h0000;
                        spi_wrt   <= 1'b1;
                        state_reg <= SPI2;
                    end else begin
                        state_reg <= RESP;
                    end
                end
                SPI2: if (spi_done) begin
                    resp_reg  <= spi_rd[7:0];
                    state_reg <= RESP;
                end
                DUMP: if (dump_done) begin
                    dump_req  <= 1'b0;
                    state_reg <= IDLE;
                end
                RESP: begin
                    trmt      <= 1'b1;
                    tx_data   <= resp_reg;
                    state_reg <= RESP_WAIT;
                end
                RESP_WAIT: if (tx_done)
                    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/cmd_dispatch.md
CMD_DISPATCH -- requirements
Module: cmd_dispatch

Interface
REQ-001 SHALL have clk, input, 1, system clock, all state on rising edge.
REQ-002 SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have rx_rdy/rx_data, input, 1/8, UART byte-received flag and byte.
REQ-004 SHALL have clr_rx_rdy, output, 1, one-cycle pulse acknowledging each byte.
REQ-005 SHALL have trmt/tx_data, output, 1/8, one-cycle response launch and response byte.
REQ-006 SHALL have tx_done, input, 1, response byte finished.
REQ-007 SHALL have spi_wrt/spi_cmd, output, 1/16, one-cycle SPI start and 16-bit word.
REQ-008 SHALL have spi_done/spi_rd, input, 1/16, SPI complete pulse and returned word.
REQ-009 SHALL have ss_sel, output, 3, target: 0=ch1, 1=ch2, 2=ch3, 3=trig pot, 4=EEP; held stable for the whole transaction.
REQ-010 SHALL have trig_pos/decimator/trig_cfg, output, 9/4/6, capture configuration registers.
REQ-011 SHALL have dump_req/dump_ch, output, 1/2, dump request level and channel; dump_done, input, 1, dump finished.
REQ-012 SHALL have capture_done, input, 1, pulse setting trig_cfg[5].

Function
REQ-013 SHALL assemble three bytes, in order opcode, byte2, byte3, pulsing clr_rx_rdy the cycle after each rx_rdy.
REQ-014 SHALL decode one cycle after byte 3 is acknowledged; states IDLE, RX2, RX3, DECODE, SPI1, SPI2, DUMP, RESP, RESP_WAIT.
REQ-015 CFG_GAIN (0x02): SHALL send spi_cmd={8'h13, LUT[byte2[4:2]]}, LUT=02,05,09,13,27,4B,8E,D1, ss_sel=byte2[1:0]; byte2[1:0]=3 -> NAK, no SPI.
REQ-016 TRIG_LVL (0x03): byte3 in 46..201 inclusive -> spi_cmd={8'h13,byte3}, ss_sel=3; else NAK, no SPI.
REQ-017 TRIG_POS (0x04): SHALL load trig_pos={byte2[0],byte3}; SET_DEC (0x05): decimator=byte3[3:0]; TRIG_CFG (0x06): trig_cfg=byte2[5:0]; all ACK, no SPI.
REQ-018 TRIG_RD (0x07): SHALL respond {2'b00,trig_cfg}.
REQ-019 EEP_WRT (0x08): SHALL send spi_cmd={2'b01,byte2[5:0],byte3}, ss_sel=4, then ACK.
REQ-020 EEP_RD (0x09): SHALL send {2'b00,byte2[5:0],8'h00}, then after spi_done a second word 16'h0000, and respond spi_rd[7:0] of the second transaction.
REQ-021 DUMP_CH (0x01): SHALL assert dump_req with dump_ch=byte2[1:0] until dump_done, then return to IDLE without a response byte.
REQ-022 Unknown opcode SHALL produce NAK 0xEE with no side effects; success ACK SHALL be 0xA5.
REQ-023 trmt SHALL pulse one cycle after the operation completes; RESP_WAIT SHALL hold until tx_done, then IDLE.
REQ-024 rx_rdy while not in IDLE/RX2/RX3 SHALL be left unacknowledged until IDLE is reached.
REQ-025 capture_done SHALL set trig_cfg[5]; coincident TRIG_CFG write SHALL win.
REQ-026 spi_wrt SHALL never be asserted while a previous transaction lacks spi_done.

Reset
REQ-027 On rst_n low SHALL immediately force IDLE, trig_pos=9'h100, decimator=0, trig_cfg=6'h03, all strobes, dump_req, tx_data, spi_cmd, ss_sel=0; mid-transaction reset abandons the command with no response.

Configuration
REQ-028 With CMD_TIMEOUT_EN defined, a 16-bit counter SHALL clear each byte and, on reaching 0xFFFF in RX2 or RX3, return to IDLE discarding partial bytes; without it, assembly SHALL wait indefinitely.

Verification
REQ-029 CFG_GAIN {02,1C,xx} -> spi_cmd 16'h13D1, ss_sel 0, response 0xA5.
REQ-030 EEP_WRT {08,2A,99} then EEP_RD {09,2A,xx} against EEPROM model -> responses 0xA5 then 0x99.
REQ-031 TRIG_LVL {03,xx,2D} -> 0xEE, no spi_wrt; {03,xx,80} -> spi_cmd 16'h1380, 0xA5.
REQ-032 TRIG_POS {04,01,80}, SET_DEC {05,xx,0F}, TRIG_CFG {06,3F,xx}, TRIG_RD -> trig_pos 9'h180, decimator 4'hF, read 0x3F.
REQ-033 Opcode 0x0A -> 0xEE, registers unchanged; reset asserted mid EEP_RD -> no trmt, reset values.
REQ-034 With CMD_TIMEOUT_EN, send one byte and idle 65536 cycles -> next three bytes decode as a fresh command.
